// File: rtl/fp2_mult_sequencer.sv
// Issue/collect wrapper around the fixed-latency Fp2 Montgomery multiplier.
// Requests are registered onto the multiplier inputs, tracked through a
// valid/tag pipe aligned with the multiplier latency, and results are
// captured into a response FIFO. Credits (queued + in flight) gate req_ready
// so a capture never finds the FIFO full.
module fp2_mult_sequencer #(
  parameter int unsigned WORD_SIZE    = 256,
  parameter int unsigned MULT_LATENCY = 8,
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_a0,
  input  logic [WORD_SIZE-1:0] req_a1,
  input  logic [WORD_SIZE-1:0] req_b0,
  input  logic [WORD_SIZE-1:0] req_b1,
  input  logic [TAG_W-1:0]     req_tag,
  output logic [WORD_SIZE-1:0] mm_a0,
  output logic [WORD_SIZE-1:0] mm_a1,
  output logic [WORD_SIZE-1:0] mm_b0,
  output logic [WORD_SIZE-1:0] mm_b1,
  input  logic [WORD_SIZE-1:0] mm_c0,
  input  logic [WORD_SIZE-1:0] mm_c1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WORD_SIZE-1:0] rsp_c0,
  output logic [WORD_SIZE-1:0] rsp_c1,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [WORD_SIZE-1:0] c0;
    logic [WORD_SIZE-1:0] c1;
    logic [TAG_W-1:0]     tag;
  } entry_t;

  logic                 ready_en_q;
  logic [CNT_W-1:0]     inflight_q, inflight_d;
  logic [CNT_W-1:0]     fifo_count_q, fifo_count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [MULT_LATENCY:0] vpipe_q, vpipe_d;
  logic [TAG_W-1:0]     tpipe_q [MULT_LATENCY+1];
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               hold_q;
  entry_t               head;
  logic [WORD_SIZE-1:0] mm_a0_q, mm_a1_q, mm_b0_q, mm_b1_q;
  logic [CNT_W:0]       credits_used;
  logic                 accept, capture, pop, fifo_full;

  // Credit check uses registered counts only, so req_ready has no
  // combinational dependency on rsp_ready or req_valid.
  assign credits_used = {1'b0, fifo_count_q} + {1'b0, inflight_q};
  assign req_ready    = ready_en_q && (credits_used < {1'b0, DEPTH_C});
  assign accept       = req_valid && req_ready;
  assign capture      = vpipe_q[MULT_LATENCY];
  assign rsp_valid    = (fifo_count_q != '0);
  assign pop          = rsp_valid && rsp_ready;
  assign fifo_full    = (fifo_count_q == DEPTH_C);
  assign busy         = (inflight_q != '0) || rsp_valid;

  assign mm_a0 = mm_a0_q;
  assign mm_a1 = mm_a1_q;
  assign mm_b0 = mm_b0_q;
  assign mm_b1 = mm_b1_q;

  // When empty the outputs show the last popped entry rather than stale RAM.
  assign head    = mem_q[rd_ptr_q];
  assign rsp_c0  = rsp_valid ? head.c0  : hold_q.c0;
  assign rsp_c1  = rsp_valid ? head.c1  : hold_q.c1;
  assign rsp_tag = rsp_valid ? head.tag : hold_q.tag;

  // Next-state for counters, pointers and the valid pipe.
  always_comb begin
    inflight_d   = inflight_q + CNT_W'(accept) - CNT_W'(capture);
    fifo_count_d = fifo_count_q + CNT_W'(capture) - CNT_W'(pop);
    wr_ptr_d     = capture ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    vpipe_d      = {vpipe_q[MULT_LATENCY-1:0], accept};
  end

  // Control state, operand registers, tag pipe and output hold register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en_q   <= 1'b0;
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      vpipe_q      <= '0;
      hold_q       <= '0;
      mm_a0_q      <= '0;
      mm_a1_q      <= '0;
      mm_b0_q      <= '0;
      mm_b1_q      <= '0;
      for (int unsigned i = 0; i <= MULT_LATENCY; i++) begin
        tpipe_q[i] <= '0;
      end
    end else begin
      ready_en_q   <= 1'b1;
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      vpipe_q      <= vpipe_d;
      tpipe_q[0]   <= req_tag;
      for (int unsigned i = 1; i <= MULT_LATENCY; i++) begin
        tpipe_q[i] <= tpipe_q[i-1];
      end
      if (pop) begin
        hold_q <= head;
      end
      if (accept) begin
        mm_a0_q <= req_a0;
        mm_a1_q <= req_a1;
        mm_b0_q <= req_b0;
        mm_b1_q <= req_b1;
      end
    end
  end

  // Response storage; capture writes the multiplier result with its tag.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_q[wr_ptr_q] <= {mm_c0, mm_c1, tpipe_q[MULT_LATENCY]};
    end
  end

  // A capture must never land in a full FIFO unless a pop frees the slot.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(capture && fifo_full && !pop));

endmodule
